lap_timer: RTL and testbench

LAP_TIMER -- requirements
Module: lap_timer

---
 rtl/lap_timer.sv | 189 ++++++++++++++++++
 tb/tb_lap_timer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lap_timer.sv
// Tenth-second lap timer: up/down cascaded BCD count, preset load, lap hold,
// and terminal-count detection with a one-cycle done pulse.
module lap_timer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int MIN_DIGITS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_btn,
  input  logic                    stop_btn,
  input  logic                    clear_btn,
  input  logic                    lap_btn,
  input  logic                    load_btn,
  input  logic                    count_down,
  input  logic [4*MIN_DIGITS-1:0] preset_min,
  input  logic [7:0]              preset_sec,
  output logic [4*MIN_DIGITS-1:0] digit_min,
  output logic [3:0]              digit_st,
  output logic [3:0]              digit_su,
  output logic [3:0]              digit_tenths,
  output logic                    running,
  output logic                    done,
  output logic                    lap_active
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [3:0]  MT_MAX = (MIN_DIGITS == 2) ? 4'd9 : 4'd0;
  localparam logic [19:0] MAXV   = {MT_MAX, 4'd9, 4'd5, 4'd9, 4'd9};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  // count layout: {min tens, min units, sec tens, sec units, tenths}
  function automatic logic [19:0] bcd_inc(input logic [19:0] c);
    logic [19:0] r;
    r = c;
    if (c != MAXV) begin
      if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
      else begin
        r[3:0] = 4'd0;
        if (c[7:4] != 4'd9) r[7:4] = c[7:4] + 4'd1;
        else begin
          r[7:4] = 4'd0;
          if (c[11:8] != 4'd5) r[11:8] = c[11:8] + 4'd1;
          else begin
            r[11:8] = 4'd0;
            if (c[15:12] != 4'd9) r[15:12] = c[15:12] + 4'd1;
            else begin
              r[15:12] = 4'd0;
              r[19:16] = c[19:16] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [19:0] bcd_dec(input logic [19:0] c);
    logic [19:0] r;
    r = c;
    if (c != 20'd0) begin
      if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
      else begin
        r[3:0] = 4'd9;
        if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
        else begin
          r[7:4] = 4'd9;
          if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
          else begin
            r[11:8] = 4'd5;
            if (c[15:12] != 4'd0) r[15:12] = c[15:12] - 4'd1;
            else begin
              r[15:12] = 4'd9;
              r[19:16] = c[19:16] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [19:0]   cnt_q, cnt_d, snap_q, snap_d, disp_q, disp_d;
  logic          lap_q, lap_d, done_q, done_d, rdy_q;
  logic          clr, ld, stp, sta, lp, tick, term;
  logic [19:0]   step, preset;
  logic [7:0]    pmin8;

  // rdy_q masks commands on the edge that releases reset
  always_comb begin
    clr = rdy_q & clear_btn;
    ld  = rdy_q & ~clear_btn & load_btn;
    stp = rdy_q & ~clear_btn & ~load_btn & stop_btn;
    sta = rdy_q & ~clear_btn & ~load_btn & ~stop_btn & start_btn;
    lp  = rdy_q & ~clear_btn & ~load_btn & ~stop_btn & ~start_btn & lap_btn;
  end

  assign tick  = (state_q == S_RUN) && (presc_q == PW'(DIV - 1));
  assign step  = count_down ? bcd_dec(cnt_q) : bcd_inc(cnt_q);
  assign term  = tick && (count_down ? (step == 20'd0) : (step == MAXV));
  assign pmin8 = 8'(preset_min);
  assign preset = {(MIN_DIGITS == 2) ? clamp9(pmin8[7:4]) : 4'd0, clamp9(pmin8[3:0]),
                   (preset_sec[7:4] > 4'd5) ? 4'd5 : preset_sec[7:4],
                   clamp9(preset_sec[3:0]), 4'd0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)                                   state_d = S_IDLE;
    else if (term)                             state_d = S_DONE;
    else if (ld && state_q != S_RUN)           state_d = S_IDLE;
    else if (stp && state_q == S_RUN)          state_d = S_PAUSE;
    else if (sta && (state_q == S_IDLE || state_q == S_PAUSE) &&
             !(count_down && cnt_q == 20'd0))  state_d = S_RUN;
  end

  always_comb begin
    running = (state_q == S_RUN);
  end

  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    snap_d  = snap_q;
    lap_d   = lap_q;
    done_d  = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      presc_d = '0;
      snap_d  = '0;
      lap_d   = 1'b0;
    end else begin
      if (state_q == S_RUN) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) cnt_d = step;
      end
      if (ld && state_q != S_RUN) begin
        cnt_d   = preset;
        presc_d = '0;
      end
      if (term) begin
        lap_d  = 1'b0;
        done_d = 1'b1;
      end else if (lp && state_q == S_RUN) begin
        if (!lap_q) snap_d = cnt_q;
        lap_d = ~lap_q;
      end
    end
    disp_d = lap_d ? snap_d : cnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      disp_q  <= '0;
      lap_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      disp_q  <= disp_d;
      lap_q   <= lap_d;
      done_q  <= done_d;
      rdy_q   <= 1'b1;
    end
  end

  assign digit_min    = disp_q[12 +: 4*MIN_DIGITS];
  assign digit_st     = disp_q[11:8];
  assign digit_su     = disp_q[7:4];
  assign digit_tenths = disp_q[3:0];
  assign done         = done_q;
  assign lap_active   = lap_q;
endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer at DIV=10, one minute digit; display compared
// as the 16-bit BCD word {min, sec tens, sec units, tenths}.
module tb_lap_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
  logic       lap_btn = 1'b0, load_btn = 1'b0, count_down = 1'b0;
  logic [3:0] preset_min = 4'h0;
  logic [7:0] preset_sec = 8'h00;
  logic [3:0] digit_min, digit_st, digit_su, digit_tenths;
  logic       running, done, lap_active;
  logic [15:0] disp;
  int n_cmp = 0, n_err = 0;

  lap_timer #(.CLK_HZ(100), .TICK_HZ(10), .MIN_DIGITS(1)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .lap_btn(lap_btn), .load_btn(load_btn),
    .count_down(count_down), .preset_min(preset_min), .preset_sec(preset_sec),
    .digit_min(digit_min), .digit_st(digit_st), .digit_su(digit_su),
    .digit_tenths(digit_tenths), .running(running), .done(done),
    .lap_active(lap_active));

  always #5 clk = ~clk;
  assign disp = {digit_min, digit_st, digit_su, digit_tenths};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // called at a negedge; the button is captured by the following posedge
  task automatic pulse(input int which);
    case (which)
      0: start_btn = 1'b1;
      1: stop_btn  = 1'b1;
      2: clear_btn = 1'b1;
      3: lap_btn   = 1'b1;
      default: load_btn = 1'b1;
    endcase
    @(negedge clk);
    {start_btn, stop_btn, clear_btn, lap_btn, load_btn} = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam int START = 0, STOP = 1, CLEAR = 2, LAP = 3, LOAD = 4;

  initial begin
    // reset state
    cyc(3);
    chk("rst_disp", disp, 16'h0000);
    chkb("rst_running", running, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_lap", lap_active, 1'b0);
    rst = 1'b1;
    start_btn = 1'b1;        // ignored: presented on the release edge
    cyc(1);
    start_btn = 1'b0;
    chkb("release_cmd_ignored", running, 1'b0);

    // count up 250 cycles
    pulse(START);
    cyc(249);
    chk("up_249", disp, 16'h0024);
    cyc(1);
    chk("up_250", disp, 16'h0025);
    chkb("up_running", running, 1'b1);
    chkb("up_done", done, 1'b0);

    // load in RUN is ignored (together with a lower-priority stop)
    preset_min = 4'h5; preset_sec = 8'h00;
    load_btn = 1'b1; stop_btn = 1'b1;
    cyc(1);
    load_btn = 1'b0; stop_btn = 1'b0;
    chkb("load_in_run_running", running, 1'b1);
    chk("load_in_run_disp", disp, 16'h0025);

    // load clamp, then count down from 0:01
    pulse(CLEAR);
    preset_min = 4'hF; preset_sec = 8'h7C;
    pulse(LOAD);
    chk("load_clamp", disp, 16'h9590);
    count_down = 1'b1;
    preset_min = 4'h0; preset_sec = 8'h01;
    pulse(LOAD);
    chk("load_001", disp, 16'h0010);
    pulse(START);
    cyc(99);
    chk("down_99", disp, 16'h0001);
    chkb("down_99_done", done, 1'b0);
    cyc(1);
    chk("down_zero", disp, 16'h0000);
    chkb("down_done_pulse", done, 1'b1);
    chkb("down_done_running", running, 1'b0);
    cyc(1);
    chkb("down_done_one_cycle", done, 1'b0);
    pulse(START);
    cyc(5);
    chkb("start_in_done", running, 1'b0);
    chk("start_in_done_disp", disp, 16'h0000);

    // start at 0:00.0 counting down is ignored
    pulse(CLEAR);
    pulse(START);
    chkb("start_at_zero_down", running, 1'b0);

    // count up to 9:59.9 and hold
    count_down = 1'b0;
    preset_min = 4'h9; preset_sec = 8'h59;
    pulse(LOAD);
    pulse(START);
    cyc(89);
    chk("max_89", disp, 16'h9598);
    chkb("max_89_done", done, 1'b0);
    cyc(1);
    chk("max_reach", disp, 16'h9599);
    chkb("max_done_pulse", done, 1'b1);
    cyc(50);
    chk("max_hold", disp, 16'h9599);
    chkb("max_hold_running", running, 1'b0);
    chkb("max_hold_done", done, 1'b0);

    // lap hold, release, stop/resume
    pulse(CLEAR);
    pulse(START);
    cyc(100);
    chk("lap_pre", disp, 16'h0010);
    pulse(LAP);
    cyc(49);
    chk("lap_frozen", disp, 16'h0010);
    chkb("lap_active_set", lap_active, 1'b1);
    pulse(LAP);
    chk("lap_release", disp, 16'h0015);
    chkb("lap_active_clr", lap_active, 1'b0);
    pulse(STOP);
    chkb("stop_running", running, 1'b0);
    cyc(30);
    chk("paused_disp", disp, 16'h0015);
    pulse(START);
    cyc(7);
    chk("resume_7", disp, 16'h0015);
    cyc(1);
    chk("resume_8", disp, 16'h0016);

    // clear beats start in the same cycle
    clear_btn = 1'b1; start_btn = 1'b1;
    cyc(1);
    clear_btn = 1'b0; start_btn = 1'b0;
    chk("clear_start_disp", disp, 16'h0000);
    chkb("clear_start_running", running, 1'b0);
    cyc(20);
    chk("clear_start_idle", disp, 16'h0000);

    // asynchronous reset mid-run with a lap held
    pulse(START);
    cyc(30);
    pulse(LAP);
    cyc(4);
    chkb("pre_rst_lap", lap_active, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_disp", disp, 16'h0000);
    chkb("async_rst_running", running, 1'b0);
    chkb("async_rst_done", done, 1'b0);
    chkb("async_rst_lap", lap_active, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    pulse(START);
    cyc(9);
    chk("post_rst_9", disp, 16'h0000);
    cyc(1);
    chk("post_rst_10", disp, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
